// File: rtl/vga_pkg.sv
// Shared VGA timing constants, oVGA bit layout and RGB332 expansion.
// The default timing is 640x480 at a 31.5 MHz pixel clock.
package vga_pkg;

    localparam int DEF_H_FRONT  = 24;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BACK   = 128;
    localparam int DEF_H_ACT    = 640;
    localparam int DEF_V_FRONT  = 9;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BACK   = 28;
    localparam int DEF_V_ACT    = 480;
    localparam bit DEF_HS_POL   = 1'b0;
    localparam bit DEF_VS_POL   = 1'b0;
    localparam int DEF_PIPE_DLY = 2;
    localparam int DEF_CW       = 11;

    localparam int OVGA_W     = 29;
    localparam int OVGA_CLK   = 28;
    localparam int OVGA_BLANK = 27;
    localparam int OVGA_SYNC  = 26;
    localparam int OVGA_VS    = 25;
    localparam int OVGA_HS    = 24;
    localparam int OVGA_R_HI  = 23;
    localparam int OVGA_R_LO  = 16;
    localparam int OVGA_G_HI  = 15;
    localparam int OVGA_G_LO  = 8;
    localparam int OVGA_B_HI  = 7;
    localparam int OVGA_B_LO  = 0;

    // Sync and blank levels as they appear at the DAC, already polarity-applied.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_t;

    function automatic logic sync_level(input logic act, input logic pol);
        return act ? pol : ~pol;
    endfunction

    // RGB332 {B[7:5],G[4:2],R[1:0]} -> {R8,G8,B8}; the LSB is replicated so full scale stays full scale.
    function automatic logic [23:0] rgb332_expand(input logic [7:0] rgb);
        logic [7:0] r8;
        logic [7:0] g8;
        logic [7:0] b8;
        r8 = {rgb[1:0], {6{rgb[0]}}};
        g8 = {rgb[4:2], {5{rgb[2]}}};
        b8 = {rgb[7:5], {5{rgb[5]}}};
        return {r8, g8, b8};
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: coordinates and markers out, RGB332 in, DAC bundle out.
interface vga_timing_gen_if #(
    parameter int CW = 11
);
    logic [7:0]    RGBIn;
    logic          displayEn;
    logic [CW-1:0] PixelX;
    logic [CW-1:0] PixelY;
    logic          inActive;
    logic          startOfFrame;
    logic          startOfLine;
    logic [15:0]   frameCount;
    logic [28:0]   oVGA;

    modport master (
        input  RGBIn,
        input  displayEn,
        output PixelX,
        output PixelY,
        output inActive,
        output startOfFrame,
        output startOfLine,
        output frameCount,
        output oVGA
    );

    modport slave (
        output RGBIn,
        output displayEn,
        input  PixelX,
        input  PixelY,
        input  inActive,
        input  startOfFrame,
        input  startOfLine,
        input  frameCount,
        input  oVGA
    );
endinterface

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH register shift with an asynchronous reset value; DEPTH=0 is a wire.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= RST_VAL;
                    end
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: raster counters, undelayed pixel coordinates/markers,
// and sync/blank delayed by the pixel-source pipeline depth so registered RGB lines up at the DAC.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int H_ACT    = DEF_H_ACT,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int V_ACT    = DEF_V_ACT,
    parameter bit HS_POL   = DEF_HS_POL,
    parameter bit VS_POL   = DEF_VS_POL,
    parameter int PIPE_DLY = DEF_PIPE_DLY,
    parameter int CW       = DEF_CW
) (
    input logic               clk,
    input logic               resetN,
    vga_timing_gen_if.master  vga
);

    localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int H_TOTAL = H_BLANK + H_ACT;
    localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int V_TOTAL = V_BLANK + V_ACT;

    generate
        if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 || H_ACT < 1 ||
            V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 || V_ACT < 1) begin : g_bad_timing
            $error("vga_timing_gen: every porch, sync and active value must be >= 1");
        end
        if (H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_bad_width
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit in CW bits");
        end
        if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
            $error("vga_timing_gen: PIPE_DLY must be within 0..7");
        end
    endgenerate

    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_LO = CW'(H_FRONT);
    localparam logic [CW-1:0] H_SYNC_HI = CW'(H_FRONT + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_LO = CW'(V_FRONT);
    localparam logic [CW-1:0] V_SYNC_HI = CW'(V_FRONT + V_SYNC);
    localparam logic [CW-1:0] H_ACT_LO  = CW'(H_BLANK);
    localparam logic [CW-1:0] V_ACT_LO  = CW'(V_BLANK);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [15:0]   frame_cnt;
    logic          h_end;
    logic          v_end;
    logic          hs_act;
    logic          vs_act;
    logic          active;
    logic          sol;
    logic          sof;
    sync_t         sync_raw;
    sync_t         sync_dly;
    logic [23:0]   rgb_exp;
    logic [23:0]   rgb_out;
    logic [28:0]   ovga;

    assign h_end = (h_cnt == H_LAST);
    assign v_end = (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_end) begin
            h_cnt <= '0;
            v_cnt <= v_end ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // The count advances on the startOfFrame clock, so the first frame after reset reads 1.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt <= '0;
        end else if (sof) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign sol    = (h_cnt == '0);
    assign sof    = sol && (v_cnt == '0);
    assign hs_act = (h_cnt >= H_SYNC_LO) && (h_cnt < H_SYNC_HI);
    assign vs_act = (v_cnt >= V_SYNC_LO) && (v_cnt < V_SYNC_HI);
    assign active = (h_cnt >= H_ACT_LO) && (v_cnt >= V_ACT_LO);

    always_comb begin
        sync_raw         = '0;
        sync_raw.hs      = sync_level(hs_act, HS_POL);
        sync_raw.vs      = sync_level(vs_act, VS_POL);
        sync_raw.blank_n = active;
    end

    // Stages reset to inactive sync and blanked, so a reset mid-pulse cannot stretch a sync.
    vga_delay_line #(
        .WIDTH   ($bits(sync_t)),
        .DEPTH   (PIPE_DLY),
        .RST_VAL ({~HS_POL, ~VS_POL, 1'b0})
    ) u_sync_dly (
        .clk    (clk),
        .resetN (resetN),
        .din    (sync_raw),
        .dout   (sync_dly)
    );

    assign rgb_exp = rgb332_expand(vga.RGBIn);
    assign rgb_out = (sync_dly.blank_n && vga.displayEn) ? rgb_exp : '0;

    always_comb begin
        ovga                        = '0;
        ovga[OVGA_CLK]              = ~clk;
        ovga[OVGA_BLANK]            = sync_dly.blank_n;
        ovga[OVGA_SYNC]             = 1'b1;
        ovga[OVGA_VS]               = sync_dly.vs;
        ovga[OVGA_HS]               = sync_dly.hs;
        ovga[OVGA_R_HI:OVGA_R_LO]   = rgb_out[23:16];
        ovga[OVGA_G_HI:OVGA_G_LO]   = rgb_out[15:8];
        ovga[OVGA_B_HI:OVGA_B_LO]   = rgb_out[7:0];
    end

    assign vga.PixelX       = active ? h_cnt - H_ACT_LO : '0;
    assign vga.PixelY       = active ? v_cnt - V_ACT_LO : '0;
    assign vga.inActive     = active;
    assign vga.startOfLine  = sol;
    assign vga.startOfFrame = sof;
    assign vga.frameCount   = frame_cnt;
    assign vga.oVGA         = ovga;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, small 14x7, small inverted-polarity direct path)
// compared against an arithmetic raster model driven by edges-since-reset counters.
module tb_vga_timing_gen;
    import vga_pkg::*;

    typedef struct {
        int hf; int hs; int hb; int ha;
        int vf; int vs; int vb; int va;
        int hpol; int vpol; int dly;
    } cfg_t;

    cfg_t c_def = '{24, 40, 128, 640, 9, 3, 28, 480, 0, 0, 2};
    cfg_t c_sm  = '{2, 2, 2, 8, 1, 1, 1, 4, 0, 0, 2};
    cfg_t c_pol = '{2, 3, 2, 8, 1, 3, 1, 4, 1, 1, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_def;
    logic rst_sm;
    logic rst_pol;
    int   checks = 0;
    int   errors = 0;
    int   n_def;
    int   n_sm;
    int   n_pol;

    // Number of rising edges seen since the reset was released.
    always @(posedge clk or negedge rst_def) if (!rst_def) n_def <= 0; else n_def <= n_def + 1;
    always @(posedge clk or negedge rst_sm)  if (!rst_sm)  n_sm  <= 0; else n_sm  <= n_sm + 1;
    always @(posedge clk or negedge rst_pol) if (!rst_pol) n_pol <= 0; else n_pol <= n_pol + 1;

    vga_timing_gen_if #(.CW(11)) if_def ();
    vga_timing_gen_if #(.CW(11)) if_sm ();
    vga_timing_gen_if #(.CW(11)) if_pol ();

    vga_timing_gen #(.PIPE_DLY(2)) dut_def (.clk(clk), .resetN(rst_def), .vga(if_def));

    vga_timing_gen #(
        .H_FRONT(2), .H_SYNC(2), .H_BACK(2), .H_ACT(8),
        .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .V_ACT(4), .PIPE_DLY(2)
    ) dut_sm (.clk(clk), .resetN(rst_sm), .vga(if_sm));

    vga_timing_gen #(
        .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .H_ACT(8),
        .V_FRONT(1), .V_SYNC(3), .V_BACK(1), .V_ACT(4),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0)
    ) dut_pol (.clk(clk), .resetN(rst_pol), .vga(if_pol));

    // ---------------- reference model ----------------
    function automatic int f_ht(cfg_t c); return c.hf + c.hs + c.hb + c.ha; endfunction
    function automatic int f_vt(cfg_t c); return c.vf + c.vs + c.vb + c.va; endfunction

    function automatic bit m_act(cfg_t c, int n);
        int h, v;
        h = n % f_ht(c);
        v = (n / f_ht(c)) % f_vt(c);
        return (h >= c.hf + c.hs + c.hb) && (v >= c.vf + c.vs + c.vb);
    endfunction

    function automatic int m_x(cfg_t c, int n);
        return m_act(c, n) ? (n % f_ht(c)) - (c.hf + c.hs + c.hb) : 0;
    endfunction

    function automatic int m_y(cfg_t c, int n);
        return m_act(c, n) ? ((n / f_ht(c)) % f_vt(c)) - (c.vf + c.vs + c.vb) : 0;
    endfunction

    function automatic bit m_hs(cfg_t c, int n);
        bit pol;
        int h;
        pol = (c.hpol != 0);
        if (n < c.dly) return !pol;
        h = (n - c.dly) % f_ht(c);
        return (h >= c.hf && h < c.hf + c.hs) ? pol : !pol;
    endfunction

    function automatic bit m_vs(cfg_t c, int n);
        bit pol;
        int v;
        pol = (c.vpol != 0);
        if (n < c.dly) return !pol;
        v = ((n - c.dly) / f_ht(c)) % f_vt(c);
        return (v >= c.vf && v < c.vf + c.vs) ? pol : !pol;
    endfunction

    function automatic bit m_blank(cfg_t c, int n);
        if (n < c.dly) return 1'b0;
        return m_act(c, n - c.dly);
    endfunction

    function automatic int m_fc(cfg_t c, int n);
        int ft;
        ft = f_ht(c) * f_vt(c);
        return ((n + ft - 1) / ft) % 65536;
    endfunction

    function automatic logic [23:0] m_rgb(logic [7:0] rgb);
        logic [1:0] r;
        logic [2:0] g, b;
        logic [7:0] r8, g8, b8;
        r  = rgb[1:0];
        g  = rgb[4:2];
        b  = rgb[7:5];
        r8 = r[0] ? {r, 6'h3F} : {r, 6'h00};
        g8 = g[0] ? {g, 5'h1F} : {g, 5'h00};
        b8 = b[0] ? {b, 5'h1F} : {b, 5'h00};
        return {r8, g8, b8};
    endfunction

    function automatic logic [28:0] m_ovga(cfg_t c, int n, logic [7:0] rgb, logic de);
        bit bl;
        bl = m_blank(c, n);
        return {1'b1, bl, 1'b1, m_vs(c, n), m_hs(c, n), (bl && de) ? m_rgb(rgb) : 24'h0};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_def = 1'b0; rst_sm = 1'b0; rst_pol = 1'b0;
        if_def.RGBIn = 8'hFF; if_def.displayEn = 1'b1;
        if_sm.RGBIn  = 8'hFF; if_sm.displayEn  = 1'b1;
        if_pol.RGBIn = 8'hFF; if_pol.displayEn = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (if_sm.PixelX !== 11'd0) begin errors++; $display("FAIL reset_pixelx got %0d want 0", if_sm.PixelX); end
        checks++; if (if_sm.PixelY !== 11'd0) begin errors++; $display("FAIL reset_pixely got %0d want 0", if_sm.PixelY); end
        checks++; if (if_sm.inActive !== 1'b0) begin errors++; $display("FAIL reset_inactive got %b want 0", if_sm.inActive); end
        checks++; if (if_sm.startOfFrame !== 1'b1) begin errors++; $display("FAIL reset_sof got %b want 1", if_sm.startOfFrame); end
        checks++; if (if_sm.startOfLine !== 1'b1) begin errors++; $display("FAIL reset_sol got %b want 1", if_sm.startOfLine); end
        checks++; if (if_sm.frameCount !== 16'd0) begin errors++; $display("FAIL reset_fc got %0d want 0", if_sm.frameCount); end
        checks++; if (if_sm.oVGA !== {5'b10111, 24'h0}) begin errors++; $display("FAIL reset_ovga_sm got %h want %h", if_sm.oVGA, {5'b10111, 24'h0}); end
        checks++; if (if_def.oVGA !== {5'b10111, 24'h0}) begin errors++; $display("FAIL reset_ovga_def got %h want %h", if_def.oVGA, {5'b10111, 24'h0}); end
        checks++; if (if_pol.oVGA !== {5'b10100, 24'h0}) begin errors++; $display("FAIL reset_ovga_pol got %h want %h", if_pol.oVGA, {5'b10100, 24'h0}); end
        @(negedge clk);
        rst_def = 1'b1; rst_sm = 1'b1; rst_pol = 1'b1;
        #1;
        checks++; if (if_def.startOfFrame !== 1'b1) begin errors++; $display("FAIL release_sof got %b want 1", if_def.startOfFrame); end
        @(negedge clk); #1;
        checks++; if (if_sm.startOfFrame !== 1'b0) begin errors++; $display("FAIL post_release_sof got %b want 0", if_sm.startOfFrame); end
        checks++; if (if_sm.frameCount !== 16'd1) begin errors++; $display("FAIL post_release_fc got %0d want 1", if_sm.frameCount); end
    endtask

    task automatic test_default_line();
        int sol_last = -1;
        int hs_low = 0;
        for (int i = 0; i < 3 * 832; i++) begin
            @(negedge clk); #1;
            checks++;
            if (if_def.oVGA[OVGA_HS] !== m_hs(c_def, n_def)) begin
                errors++; $display("FAIL def_hs n=%0d got %b want %b", n_def, if_def.oVGA[OVGA_HS], m_hs(c_def, n_def));
            end
            checks++;
            if (if_def.PixelX !== 11'(m_x(c_def, n_def))) begin
                errors++; $display("FAIL def_pixelx n=%0d got %0d want %0d", n_def, if_def.PixelX, m_x(c_def, n_def));
            end
            if (if_def.startOfLine === 1'b1) begin
                if (sol_last >= 0) begin
                    checks++; if (i - sol_last != 832) begin errors++; $display("FAIL def_line_period got %0d want 832", i - sol_last); end
                    checks++; if (hs_low != 40) begin errors++; $display("FAIL def_hs_width got %0d want 40", hs_low); end
                end
                sol_last = i;
                hs_low = 0;
            end
            if (if_def.oVGA[OVGA_HS] === 1'b0 && sol_last >= 0) begin
                hs_low++;
                checks++;
                if (i - sol_last < 26 || i - sol_last > 65) begin
                    errors++; $display("FAIL def_hs_offset got %0d want 26..65", i - sol_last);
                end
            end
        end
        checks++; if (sol_last < 0) begin errors++; $display("FAIL def_sol_seen got none want pulse"); end
    endtask

    task automatic test_small_scoreboard();
        int last_sof = -1;
        bit first_seen = 0;
        logic [28:0] exp_ovga;
        for (int i = 0; i < 3 * 98 + 20; i++) begin
            @(negedge clk); #1;
            exp_ovga = m_ovga(c_sm, n_sm, if_sm.RGBIn, if_sm.displayEn);
            checks++; if (if_sm.PixelX !== 11'(m_x(c_sm, n_sm))) begin errors++; $display("FAIL sm_pixelx n=%0d got %0d want %0d", n_sm, if_sm.PixelX, m_x(c_sm, n_sm)); end
            checks++; if (if_sm.PixelY !== 11'(m_y(c_sm, n_sm))) begin errors++; $display("FAIL sm_pixely n=%0d got %0d want %0d", n_sm, if_sm.PixelY, m_y(c_sm, n_sm)); end
            checks++; if (if_sm.inActive !== m_act(c_sm, n_sm)) begin errors++; $display("FAIL sm_inactive n=%0d got %b want %b", n_sm, if_sm.inActive, m_act(c_sm, n_sm)); end
            checks++; if (if_sm.startOfLine !== (n_sm % 14 == 0)) begin errors++; $display("FAIL sm_sol n=%0d got %b want %b", n_sm, if_sm.startOfLine, (n_sm % 14 == 0)); end
            checks++; if (if_sm.startOfFrame !== (n_sm % 98 == 0)) begin errors++; $display("FAIL sm_sof n=%0d got %b want %b", n_sm, if_sm.startOfFrame, (n_sm % 98 == 0)); end
            checks++; if (if_sm.frameCount !== 16'(m_fc(c_sm, n_sm))) begin errors++; $display("FAIL sm_fc n=%0d got %0d want %0d", n_sm, if_sm.frameCount, m_fc(c_sm, n_sm)); end
            checks++; if (if_sm.oVGA !== exp_ovga) begin errors++; $display("FAIL sm_ovga n=%0d got %h want %h", n_sm, if_sm.oVGA, exp_ovga); end
            if (if_sm.inActive === 1'b1 && !first_seen) begin
                first_seen = 1;
                checks++;
                if (n_sm % 14 != 6 || (n_sm / 14) % 7 != 3 || if_sm.PixelX !== 11'd0 || if_sm.PixelY !== 11'd0) begin
                    errors++; $display("FAIL sm_first_pixel got h=%0d v=%0d x=%0d y=%0d want h=6 v=3 x=0 y=0",
                                       n_sm % 14, (n_sm / 14) % 7, if_sm.PixelX, if_sm.PixelY);
                end
            end
            if (if_sm.startOfFrame === 1'b1) begin
                if (last_sof >= 0) begin
                    checks++; if (i - last_sof != 98) begin errors++; $display("FAIL sm_frame_period got %0d want 98", i - last_sof); end
                end
                last_sof = i;
            end
            if_sm.RGBIn     = 8'($urandom);
            if_sm.displayEn = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic test_polarity();
        int guard = 0;
        int hs_line = 0;
        int vs_total = 0;
        @(negedge clk); #1;
        while (if_pol.startOfFrame !== 1'b1 && guard < 300) begin
            @(negedge clk); #1;
            guard++;
        end
        checks++; if (guard >= 300) begin errors++; $display("FAIL pol_sof_timeout got none want pulse"); end
        for (int i = 0; i < 135; i++) begin
            checks++;
            if (if_pol.oVGA[OVGA_HS] !== m_hs(c_pol, n_pol) || if_pol.oVGA[OVGA_VS] !== m_vs(c_pol, n_pol)) begin
                errors++; $display("FAIL pol_sync n=%0d got hs=%b vs=%b want hs=%b vs=%b", n_pol,
                                   if_pol.oVGA[OVGA_HS], if_pol.oVGA[OVGA_VS], m_hs(c_pol, n_pol), m_vs(c_pol, n_pol));
            end
            if (if_pol.oVGA[OVGA_HS] === 1'b1) hs_line++;
            if (if_pol.oVGA[OVGA_VS] === 1'b1) vs_total++;
            if (i % 15 == 14) begin
                checks++; if (hs_line != 3) begin errors++; $display("FAIL pol_hs_width got %0d want 3", hs_line); end
                hs_line = 0;
            end
            @(negedge clk); #1;
        end
        checks++; if (vs_total != 45) begin errors++; $display("FAIL pol_vs_width got %0d want 45 (3 lines)", vs_total); end
    endtask

    task automatic test_rgb();
        int guard = 0;
        if_sm.RGBIn = 8'b111_000_11;
        if_sm.displayEn = 1'b1;
        @(negedge clk); #1;
        while (!m_blank(c_sm, n_sm) && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        checks++; if (guard >= 200) begin errors++; $display("FAIL rgb_active_timeout got none want active"); end
        checks++; if (if_sm.oVGA[23:0] !== 24'hFF00FF) begin errors++; $display("FAIL rgb_expand got %h want ff00ff", if_sm.oVGA[23:0]); end
        if_sm.displayEn = 1'b0; #1;
        checks++; if (if_sm.oVGA[23:0] !== 24'h000000) begin errors++; $display("FAIL rgb_display_off got %h want 000000", if_sm.oVGA[23:0]); end
        if_sm.displayEn = 1'b1;
        if_sm.RGBIn = 8'b010_101_10; #1;
        checks++; if (if_sm.oVGA[23:0] !== 24'h80BF40) begin errors++; $display("FAIL rgb_expand2 got %h want 80bf40", if_sm.oVGA[23:0]); end
        guard = 0;
        while (m_blank(c_sm, n_sm) && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        checks++; if (if_sm.oVGA[23:0] !== 24'h000000 || guard >= 200) begin errors++; $display("FAIL rgb_blanking got %h want 000000", if_sm.oVGA[23:0]); end
    endtask

    task automatic test_reset_mid_frame();
        int guard = 0;
        @(negedge clk); #1;
        while (!(n_sm >= 3 * 98 && n_sm % 14 == 4 && (n_sm / 14) % 7 == 1) && guard < 500) begin
            @(negedge clk); #1;
            guard++;
        end
        checks++; if (guard >= 500) begin errors++; $display("FAIL rst_mid_timeout got none want h=4 v=1"); end
        checks++; if (if_sm.frameCount !== 16'(m_fc(c_sm, n_sm))) begin errors++; $display("FAIL rst_mid_fc_before got %0d want %0d", if_sm.frameCount, m_fc(c_sm, n_sm)); end
        checks++; if (if_sm.oVGA[OVGA_VS] !== m_vs(c_sm, n_sm)) begin errors++; $display("FAIL rst_mid_vs_before got %b want %b", if_sm.oVGA[OVGA_VS], m_vs(c_sm, n_sm)); end
        rst_sm = 1'b0; #1;
        checks++; if (if_sm.PixelX !== 11'd0 || if_sm.PixelY !== 11'd0) begin errors++; $display("FAIL rst_mid_pixel got x=%0d y=%0d want 0 0", if_sm.PixelX, if_sm.PixelY); end
        checks++; if (if_sm.startOfFrame !== 1'b1 || if_sm.startOfLine !== 1'b1) begin errors++; $display("FAIL rst_mid_markers got sof=%b sol=%b want 1 1", if_sm.startOfFrame, if_sm.startOfLine); end
        checks++; if (if_sm.frameCount !== 16'd0) begin errors++; $display("FAIL rst_mid_fc got %0d want 0", if_sm.frameCount); end
        checks++; if (if_sm.oVGA[28:24] !== 5'b10111) begin errors++; $display("FAIL rst_mid_sync got %b want 10111", if_sm.oVGA[28:24]); end
        repeat (2) @(negedge clk);
        #1;
        rst_sm = 1'b1; #1;
        checks++; if (if_sm.startOfFrame !== 1'b1) begin errors++; $display("FAIL rst_rel_sof got %b want 1", if_sm.startOfFrame); end
        @(negedge clk); #1;
        checks++; if (if_sm.frameCount !== 16'd1) begin errors++; $display("FAIL rst_rel_fc1 got %0d want 1", if_sm.frameCount); end
        guard = 0;
        while (n_sm < 99 && guard < 200) begin
            @(negedge clk); #1;
            guard++;
            checks++;
            if (if_sm.frameCount !== 16'(m_fc(c_sm, n_sm))) begin errors++; $display("FAIL rst_rel_fc n=%0d got %0d want %0d", n_sm, if_sm.frameCount, m_fc(c_sm, n_sm)); end
        end
        checks++; if (if_sm.frameCount !== 16'd2) begin errors++; $display("FAIL rst_rel_fc2 got %0d want 2", if_sm.frameCount); end
    endtask

    initial begin
        test_reset();
        test_default_line();
        test_small_scoreboard();
        test_polarity();
        test_rgb();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
